lsu_sram_requester: RTL and testbench

- Load/store-unit-side initiator for the 32-bit SRAM controller. The controller is the 18-bit halfword-addressed IS61WV25616 interface with 2-cycle write and 3-cycle read.
- Takes one RV32 load/store request from the core and checks alignment and range.
- Builds the word address, byte mask and replicated write data, then issues a single-cycle request pulse to the controller and waits for ack.
- Formats and sign/zero-extends load data, and returns done/error with a stall to the core.

---
 rtl/lsu_sram_requester.sv | 185 ++++++++++++++++++
 tb/tb_lsu_sram_requester.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sram_requester.sv
// Load/store-unit initiator for the 32-bit SRAM controller: checks one RV32 access,
// issues a single request pulse, waits for ack (with timeout) and formats load data.
//
// state | meaning
// IDLE  | waiting for a core request; checks funct3, alignment and range
// REQ   | one-cycle wren/rden pulse to the controller
// WAIT  | waiting for ack, timeout counter running
// DONE  | one-cycle done pulse with err/rdata back to the core
module lsu_sram_requester #(
  parameter int TIMEOUT_CYC = 16,
  parameter int ADDR_MSB    = 18
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_lsu_valid,
  input  logic                i_lsu_we,
  input  logic [2:0]          i_lsu_funct3,
  input  logic [31:0]         i_lsu_addr,
  input  logic [31:0]         i_lsu_wdata,
  output logic [31:0]         o_lsu_rdata,
  output logic                o_lsu_done,
  output logic                o_lsu_err,
  output logic                o_lsu_stall,
  output logic [ADDR_MSB-1:0] o_sram_addr,
  output logic [31:0]         o_sram_wdata,
  output logic [3:0]          o_sram_bmask,
  output logic                o_sram_wren,
  output logic                o_sram_rden,
  input  logic [31:0]         i_sram_rdata,
  input  logic                i_sram_ack
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     tmo_cnt;
  logic                 we_q;
  logic [2:0]           funct3_q;
  logic [1:0]           off_q;
  logic                 err_q;
  logic [31:0]          rdata_q;
  logic [ADDR_MSB-1:0]  sram_addr_q;
  logic [31:0]          sram_wdata_q;
  logic [3:0]           bmask_q;

  logic                 f3_ok, misalign, out_of_range, req_bad, timeout;
  logic [3:0]           bmask_nxt;
  logic [31:0]          wdata_nxt;
  logic [31:0]          shifted, load_fmt;

  always_comb begin
    f3_ok = 1'b0;
    if (i_lsu_we) f3_ok = i_lsu_funct3 inside {3'b000, 3'b001, 3'b010};
    else          f3_ok = i_lsu_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misalign     = ((i_lsu_funct3[1:0] == 2'b01) && i_lsu_addr[0]) ||
                   ((i_lsu_funct3[1:0] == 2'b10) && (i_lsu_addr[1:0] != 2'b00));
    out_of_range = |i_lsu_addr[31:ADDR_MSB+1];
    req_bad      = !f3_ok || misalign || out_of_range;
  end

  // Narrow stores are replicated across lanes; the mask selects the live bytes.
  always_comb begin
    bmask_nxt = 4'b1111;
    wdata_nxt = 32'h0;
    if (i_lsu_we) begin
      case (i_lsu_funct3[1:0])
        2'b00: begin
          bmask_nxt = 4'b0001 << i_lsu_addr[1:0];
          wdata_nxt = {4{i_lsu_wdata[7:0]}};
        end
        2'b01: begin
          bmask_nxt = 4'b0011 << i_lsu_addr[1:0];
          wdata_nxt = {2{i_lsu_wdata[15:0]}};
        end
        default: begin
          bmask_nxt = 4'b1111;
          wdata_nxt = i_lsu_wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted  = i_sram_rdata >> {off_q, 3'b000};
    load_fmt = shifted;
    case (funct3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_fmt = {24'h0, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_fmt = {16'h0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  // Ack takes priority over a timeout landing in the same cycle.
  assign timeout = (state == WAIT) && !i_sram_ack && (tmo_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_sram_wren = 1'b0;
    o_sram_rden = 1'b0;
    o_lsu_done  = 1'b0;
    o_lsu_err   = 1'b0;
    o_lsu_rdata = 32'h0;
    o_lsu_stall = 1'b0;
    case (state)
      IDLE: begin
        o_lsu_stall = i_lsu_valid;
        if (i_lsu_valid) state_nxt = req_bad ? DONE : REQ;
      end
      REQ: begin
        o_lsu_stall = 1'b1;
        o_sram_wren = we_q;
        o_sram_rden = !we_q;
        state_nxt   = WAIT;
      end
      WAIT: begin
        o_lsu_stall = 1'b1;
        if (i_sram_ack || timeout) state_nxt = DONE;
      end
      DONE: begin
        o_lsu_done  = 1'b1;
        o_lsu_err   = err_q;
        o_lsu_rdata = rdata_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      tmo_cnt      <= '0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
      bmask_q      <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (i_lsu_valid) begin
            rdata_q <= 32'h0;
            err_q   <= req_bad;
            if (!req_bad) begin
              we_q         <= i_lsu_we;
              funct3_q     <= i_lsu_funct3;
              off_q        <= i_lsu_addr[1:0];
              sram_addr_q  <= {i_lsu_addr[ADDR_MSB:2], 1'b0};
              sram_wdata_q <= wdata_nxt;
              bmask_q      <= bmask_nxt;
            end
          end
        end
        REQ: tmo_cnt <= CNT_W'(TIMEOUT_CYC - 1);
        WAIT: begin
          if (i_sram_ack) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0 : load_fmt;
          end else if (tmo_cnt == '0) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sram_addr  = sram_addr_q;
  assign o_sram_wdata = sram_wdata_q;
  assign o_sram_bmask = bmask_q;

endmodule

// File: tb/tb_lsu_sram_requester.sv
// Bench for lsu_sram_requester: directed test-plan steps then random accesses, checked
// against a byte-level memory model and cycle-count rules.
module tb_lsu_sram_requester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, we = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] lsu_rdata;
  logic        done, err, stall;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_bmask;
  logic        wren, rden;
  logic [31:0] sram_rdata = 32'h0;
  logic        ack = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram    [0:255];
  logic [7:0]  ref_mem [0:1023];

  always #5 clk = ~clk;

  lsu_sram_requester dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_lsu_valid(valid), .i_lsu_we(we), .i_lsu_funct3(f3),
    .i_lsu_addr(addr), .i_lsu_wdata(wdata),
    .o_lsu_rdata(lsu_rdata), .o_lsu_done(done), .o_lsu_err(err), .o_lsu_stall(stall),
    .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .o_sram_bmask(sram_bmask),
    .o_sram_wren(wren), .o_sram_rden(rden),
    .i_sram_rdata(sram_rdata), .i_sram_ack(ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    sram[idx] = w;
    for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = w[8*b +: 8];
  endtask

  function automatic logic ref_err(input logic st, input logic [2:0] fn, input logic [31:0] a);
    int  size;
    bit  fn_ok;
    size  = 1 << fn[1:0];
    fn_ok = st ? (fn <= 3'd2) : (fn != 3'd3 && fn < 3'd6);
    return !fn_ok || (a % size != 0) || (a >= 32'h0008_0000);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] fn, input logic [31:0] a);
    longint v;
    int     size;
    size = 1 << fn[1:0];
    v = 0;
    for (int i = 0; i < size; i++) v = v | (longint'(ref_mem[(a + i) % 1024]) << (8*i));
    if (!fn[2] && (((v >> (8*size - 1)) & 1) == 1)) v = v - (longint'(1) << (8*size));
    return v[31:0];
  endfunction

  // One core access; ack_at is the cycle (request = cycle 0) in which ack is driven, -1 = never.
  task automatic op(input logic st, input logic [2:0] fn, input logic [31:0] a,
                    input logic [31:0] wd, input int ack_at,
                    output logic [31:0] rd, output logic er,
                    output logic [17:0] c_addr, output logic [3:0] c_bm, output logic [31:0] c_wd);
    int  done_c = -1, n_wr = 0, n_rd = 0, pulse_c = -1, stall_bad = 0, stable_bad = 0, both = 0;
    int  size, off, exp_done;
    logic e_req, ack_ok, exp_err;
    logic [31:0] exp_rd, exp_wd, lane_m;
    logic [3:0]  exp_bm;
    c_addr = '0; c_bm = '0; c_wd = '0; rd = '0; er = 1'b0;
    size   = 1 << fn[1:0];
    off    = int'(a % 4);
    e_req  = ref_err(st, fn, a);
    ack_ok = (ack_at >= 2) && (ack_at <= 17);
    exp_err  = e_req || !ack_ok;
    exp_done = e_req ? 1 : (ack_ok ? ack_at + 1 : 18);
    exp_rd   = (!st && !exp_err) ? ref_load(fn, a) : 32'h0;
    exp_bm   = st ? 4'(((1 << size) - 1) << off) : 4'hF;
    exp_wd   = 32'h0;
    lane_m   = 32'h0;
    if (st) for (int i = 0; i < size && i < 4; i++) begin
      exp_wd[8*(off+i) +: 8] = wd[8*i +: 8];
      lane_m[8*(off+i) +: 8] = 8'hFF;
    end
    if (st && !e_req) for (int i = 0; i < size; i++) ref_mem[(a + i) % 1024] = wd[8*i +: 8];

    @(negedge clk);
    valid = 1'b1; we = st; f3 = fn; addr = a; wdata = wd;
    for (int c = 0; c < 25; c++) begin
      if (wren && rden) both++;
      if (wren || rden) begin
        n_wr += int'(wren); n_rd += int'(rden); pulse_c = c;
        c_addr = sram_addr; c_bm = sram_bmask; c_wd = sram_wdata;
        if (wren) for (int b = 0; b < 4; b++)
          if (sram_bmask[b]) sram[sram_addr[8:1]][8*b +: 8] = sram_wdata[8*b +: 8];
      end
      ack = (c == ack_at);
      sram_rdata = ack ? sram[c_addr[8:1]] : $urandom;
      #1;
      if (stall !== !done) stall_bad++;
      if (done) begin
        done_c = c; er = err; rd = lsu_rdata;
        if (pulse_c >= 0 && (sram_addr !== c_addr || sram_bmask !== c_bm || sram_wdata !== c_wd))
          stable_bad++;
        break;
      end
      @(negedge clk);
    end
    valid = 1'b0; ack = 1'b0;

    check("done_cycle", 32'(done_c), 32'(exp_done));
    check("lsu_err", 32'(er), 32'(exp_err));
    check("lsu_rdata", rd, exp_rd);
    check("wren_pulses", 32'(n_wr), 32'(st && !e_req));
    check("rden_pulses", 32'(n_rd), 32'(!st && !e_req));
    check("wren_and_rden", 32'(both), 32'h0);
    check("stall_profile", 32'(stall_bad), 32'h0);
    if (!e_req) begin
      check("pulse_cycle", 32'(pulse_c), 32'h1);
      check("sram_addr", 32'(c_addr), (a >> 2) << 1);
      check("sram_bmask", 32'(c_bm), 32'(exp_bm));
      if (st) check("sram_wdata_lanes", c_wd & lane_m, exp_wd);
      check("req_fields_stable", 32'(stable_bad), 32'h0);
    end
  endtask

  logic [31:0] rd, wd_r, a_r;
  logic        er, st_r;
  logic [17:0] ca;
  logic [3:0]  cb;
  logic [31:0] cw;
  logic [2:0]  fn_r;
  int          ack_r, size_r, stray;

  initial begin
    for (int i = 0; i < 256; i++) set_word(i, $urandom);

    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", lsu_rdata, 32'h0);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    check("rst_sram_wdata", sram_wdata, 32'h0);
    check("rst_sram_bmask", 32'(sram_bmask), 32'h0);
    check("rst_req", 32'({wren, rden}), 32'h0);
    rst_n = 1'b1;

    op(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 3, rd, er, ca, cb, cw);
    check("sw_addr", 32'(ca), 32'h082);
    check("sw_bmask", 32'(cb), 32'hF);
    check("sw_wdata", cw, 32'hDEAD_BEEF);
    op(1'b1, 3'b000, 32'h0000_0107, 32'h0000_00A5, 3, rd, er, ca, cb, cw);
    check("sb_bmask", 32'(cb), 32'h8);
    check("sb_wdata", cw, 32'hA5A5_A5A5);
    check("sb_addr", 32'(ca), 32'h082);

    set_word(128, 32'h80F1_7F22);
    op(1'b0, 3'b000, 32'h203, 32'h0, 4, rd, er, ca, cb, cw); check("lb_203", rd, 32'hFFFF_FF80);
    op(1'b0, 3'b100, 32'h203, 32'h0, 4, rd, er, ca, cb, cw); check("lbu_203", rd, 32'h0000_0080);
    op(1'b0, 3'b001, 32'h202, 32'h0, 4, rd, er, ca, cb, cw); check("lh_202", rd, 32'hFFFF_80F1);
    op(1'b0, 3'b101, 32'h200, 32'h0, 4, rd, er, ca, cb, cw); check("lhu_200", rd, 32'h0000_7F22);
    op(1'b0, 3'b010, 32'h200, 32'h0, 4, rd, er, ca, cb, cw); check("lw_200", rd, 32'h80F1_7F22);

    op(1'b0, 3'b010, 32'h0000_0102, 32'h0, 4, rd, er, ca, cb, cw); check("lw_misalign_err", 32'(er), 32'h1);
    op(1'b1, 3'b001, 32'h0000_0001, 32'h1234, 3, rd, er, ca, cb, cw); check("sh_misalign_err", 32'(er), 32'h1);
    op(1'b0, 3'b000, 32'h0008_0000, 32'h0, 4, rd, er, ca, cb, cw); check("lb_range_err", 32'(er), 32'h1);
    op(1'b1, 3'b100, 32'h0000_0010, 32'h55, 3, rd, er, ca, cb, cw); check("store_bad_f3_err", 32'(er), 32'h1);

    op(1'b0, 3'b010, 32'h200, 32'h0, -1, rd, er, ca, cb, cw); check("timeout_err", 32'(er), 32'h1);
    op(1'b0, 3'b010, 32'h200, 32'h0, 17, rd, er, ca, cb, cw);
    check("ack_at_timeout_err", 32'(er), 32'h0);
    check("ack_at_timeout_data", rd, 32'h80F1_7F22);

    // Reset while waiting for ack, then a stray ack in IDLE.
    @(negedge clk);
    valid = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h200;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_wait_stall", 32'(stall), 32'h0);
    check("rst_wait_done", 32'(done), 32'h0);
    check("rst_wait_req", 32'({wren, rden}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    ack = 1'b1; sram_rdata = 32'h1357_9BDF;
    @(negedge clk);
    ack = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (done || stall) stray++;
      @(negedge clk);
    end
    check("stray_ack_ignored", 32'(stray), 32'h0);
    op(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 3, rd, er, ca, cb, cw);
    check("sw_after_reset_err", 32'(er), 32'h0);
    op(1'b0, 3'b010, 32'h0000_0040, 32'h0, 4, rd, er, ca, cb, cw);
    check("lw_after_reset", rd, 32'hCAFE_F00D);

    for (int n = 0; n < 60; n++) begin
      st_r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) fn_r = 3'($urandom_range(0, 7));
      else if (st_r) fn_r = 3'($urandom_range(0, 2));
      else begin
        fn_r = 3'($urandom_range(0, 4));
        if (fn_r == 3'd3) fn_r = 3'd5;
      end
      size_r = 1 << fn_r[1:0];
      a_r = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 4) != 0) a_r = a_r & ~32'(size_r - 1);
      if ($urandom_range(0, 9) == 0) a_r = a_r | (32'h1 << $urandom_range(19, 31));
      wd_r = $urandom;
      ack_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 8)) : (st_r ? 3 : 4);
      op(st_r, fn_r, a_r, wd_r, ack_r, rd, er, ca, cb, cw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
